// File: rtl/zap_block_xfer_mem_seq_pkg.sv
// Shared definitions for the LDM/STM memory-side sequencer.
// Optional build macro: ZAP_BLOCK_XFER_ALIGN_CHK_EN (misaligned base aborts at accept).
package zap_block_xfer_mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Block-transfer instruction bit positions (P/U/W/L).
  localparam int unsigned BIT_P = 24;
  localparam int unsigned BIT_U = 23;
  localparam int unsigned BIT_W = 21;
  localparam int unsigned BIT_L = 20;

endpackage

// File: rtl/zap_block_xfer_pri_enc.sv
// Lowest-set-bit encoder plus popcount over a register list.
module zap_block_xfer_pri_enc #(
  parameter  int NREGS = 16,
  localparam int IDX_W = $clog2(NREGS),
  localparam int CNT_W = $clog2(NREGS + 1)
) (
  input  logic [NREGS-1:0] i_list,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx,
  output logic [CNT_W-1:0] o_count
);

  always_comb begin
    o_any   = |i_list;
    o_idx   = '0;
    o_count = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (i_list[i]) o_idx = IDX_W'(i);
    end
    for (int i = 0; i < NREGS; i++) begin
      o_count = o_count + CNT_W'(i_list[i]);
    end
  end

endmodule

// File: rtl/zap_block_xfer_mem_seq.sv
// LDM/STM memory sequencer: walks the register list lowest-first, one word beat per register.
// Optional build macro: ZAP_BLOCK_XFER_ALIGN_CHK_EN (misaligned base aborts; otherwise base[1:0] is forced to 0).
//
// state    | meaning
// ST_IDLE  | waiting for a descriptor, o_busy=0
// ST_REQ   | presenting the current beat on the memory interface
// ST_DONE  | one-cycle completion pulse, optional base writeback
// ST_ABORT | one-cycle abort pulse, original base reported
module zap_block_xfer_mem_seq #(
  parameter  int ADDR_W = 32,
  parameter  int NREGS  = 16,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [NREGS-1:0]  i_reglist,
  input  logic              i_pre_index,
  input  logic              i_up,
  input  logic              i_load,
  input  logic              i_writeback,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic [IDX_W-1:0]  o_mem_reg,
  input  logic              i_mem_ack,
  input  logic              i_mem_abort,
  output logic              o_done,
  output logic              o_abort,
  output logic              o_wb_valid,
  output logic [ADDR_W-1:0] o_wb_value
);
  import zap_block_xfer_mem_seq_pkg::*;

  localparam int CNT_W = $clog2(NREGS + 1);
  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic [IDX_W-1:0]  reg_q, reg_d;
  logic              wr_q, wr_d;
  logic              wb_en_q, wb_en_d;

  logic [NREGS-1:0]  list_rem, enc_in;
  logic              enc_any;
  logic [IDX_W-1:0]  enc_idx;
  logic [CNT_W-1:0]  enc_cnt;
  logic [ADDR_W-1:0] base_eff, span, start_addr, final_base;
  logic              misaligned;

  // Registers still owed after the current beat; in IDLE the encoder looks at the new list.
  assign list_rem = list_q & ~(NREGS'(1) << reg_q);
  assign enc_in   = (state_q == ST_IDLE) ? i_reglist : list_rem;

  zap_block_xfer_pri_enc #(.NREGS(NREGS)) u_pri_enc (
    .i_list  (enc_in),
    .o_any   (enc_any),
    .o_idx   (enc_idx),
    .o_count (enc_cnt)
  );

`ifdef ZAP_BLOCK_XFER_ALIGN_CHK_EN
  assign base_eff   = i_base;
  assign misaligned = |(i_base & ADDR_W'(3));
`else
  assign base_eff   = i_base & ~ADDR_W'(3);
  assign misaligned = 1'b0;
`endif

  assign span       = ADDR_W'(enc_cnt) * WORD;
  assign final_base = i_up ? base_eff + span : base_eff - span;

  always_comb begin
    case ({i_pre_index, i_up})
      2'b01:   start_addr = base_eff;
      2'b11:   start_addr = base_eff + WORD;
      2'b00:   start_addr = base_eff - span + WORD;
      default: start_addr = base_eff - span;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    reg_d      = reg_q;
    wr_d       = wr_q;
    base_d     = base_q;
    wb_d       = wb_q;
    wb_en_d    = wb_en_q;
    o_busy     = (state_q != ST_IDLE);
    o_mem_req  = (state_q == ST_REQ);
    o_done     = 1'b0;
    o_abort    = 1'b0;
    o_wb_valid = 1'b0;
    o_wb_value = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d  = base_eff;
          wb_d    = final_base;
          wb_en_d = i_writeback && enc_any;
          wr_d    = ~i_load;
          if (!enc_any) begin
            state_d = ST_DONE;
          end else if (misaligned) begin
            state_d = ST_ABORT;
          end else begin
            state_d = ST_REQ;
            list_d  = i_reglist;
            addr_d  = start_addr;
            reg_d   = enc_idx;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_abort) begin
          state_d = ST_ABORT;
        end else if (i_mem_ack) begin
          if (enc_any) begin
            list_d = list_rem;
            addr_d = addr_q + WORD;
            reg_d  = enc_idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        o_wb_valid = wb_en_q;
        o_wb_value = wb_q;
        state_d    = ST_IDLE;
      end
      default: begin
        o_abort    = 1'b1;
        o_wb_valid = 1'b1;
        o_wb_value = base_q;
        state_d    = ST_IDLE;
      end
    endcase

    if (i_clear) state_d = ST_IDLE;

    // Bus-facing registers read as zero whenever no beat is being presented.
    if (state_d != ST_REQ) begin
      list_d = '0;
      addr_d = '0;
      reg_d  = '0;
      wr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      wr_q    <= 1'b0;
      base_q  <= '0;
      wb_q    <= '0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      wb_q    <= wb_d;
      wb_en_q <= wb_en_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_reg  = reg_q;
  assign o_mem_wr   = wr_q;

endmodule

// File: tb/tb_zap_block_xfer_mem_seq.sv
// Self-checking bench for zap_block_xfer_mem_seq: directed table, random transfers, corner sequences.
module tb_zap_block_xfer_mem_seq;

  logic        clk = 1'b0;
  logic        i_reset_n, i_clear, i_start, i_pre_index, i_up, i_load, i_writeback;
  logic [31:0] i_base;
  logic [15:0] i_reglist;
  logic        i_mem_ack, i_mem_abort;
  logic        o_busy, o_mem_req, o_mem_wr, o_done, o_abort, o_wb_valid;
  logic [31:0] o_mem_addr, o_wb_value;
  logic [3:0]  o_mem_reg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zap_block_xfer_mem_seq #(.ADDR_W(32), .NREGS(16)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_start(i_start),
    .i_base(i_base), .i_reglist(i_reglist), .i_pre_index(i_pre_index), .i_up(i_up),
    .i_load(i_load), .i_writeback(i_writeback), .o_busy(o_busy), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr), .o_mem_reg(o_mem_reg),
    .i_mem_ack(i_mem_ack), .i_mem_abort(i_mem_abort), .o_done(o_done), .o_abort(o_abort),
    .o_wb_valid(o_wb_valid), .o_wb_value(o_wb_value)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] list;
    logic        p, u, l, w;
    int          abort_beat;
    logic [31:0] exp_first;
    logic        exp_done, exp_abort, exp_wbvld;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_req"}, o_mem_req, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_pulses"}, {o_done, o_abort, o_wb_valid}, 0);
  endtask

  // Reference model: the transferred words form a contiguous window of 4N bytes
  // next to the base; its lower end is exclusive (start one word up) when P==U.
  task automatic run_xfer(input logic [31:0] base, input logic [15:0] list,
                          input logic p, input logic u, input logic l, input logic w,
                          input int abort_beat, input int max_stall, input bit junk,
                          output logic [31:0] first_addr, output logic [31:0] wbv,
                          output logic wbvld, output logic done, output logic abrt);
    int n;
    int regs[$];
    logic [31:0] b, lo, exp_wb;
    bit mis, aborted;
    int stall;
    n = 0;
    regs = {};
    for (int i = 0; i < 16; i++) if (list[i]) begin regs.push_back(i); n++; end
`ifdef ZAP_BLOCK_XFER_ALIGN_CHK_EN
    b   = base;
    mis = (base[1:0] != 2'b00) && (n > 0);
`else
    b   = {base[31:2], 2'b00};
    mis = 0;
`endif
    lo = u ? b : b - 32'(4 * n);
    if (p == u) lo = lo + 32'd4;
    exp_wb = u ? b + 32'(4 * n) : b - 32'(4 * n);

    i_base = base; i_reglist = list; i_pre_index = p; i_up = u; i_load = l; i_writeback = w;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    first_addr = '0;
    aborted = 0;
    if (mis) aborted = 1;
    else if (n > 0) begin
      for (int k = 0; k < n; k++) begin
        chk("beat_req", o_mem_req, 1);
        chk("beat_busy", o_busy, 1);
        chk("beat_addr", o_mem_addr, lo + 32'(4 * k));
        chk("beat_reg", o_mem_reg, regs[k]);
        chk("beat_wr", o_mem_wr, !l);
        if (k == 0) first_addr = o_mem_addr;
        stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
        for (int s = 0; s < stall; s++) begin
          if (junk) begin
            i_start = 1'($urandom); i_base = $urandom; i_reglist = 16'($urandom);
            i_up = 1'($urandom); i_pre_index = 1'($urandom); i_load = 1'($urandom);
          end
          @(negedge clk);
          chk("stall_req", o_mem_req, 1);
          chk("stall_addr", o_mem_addr, lo + 32'(4 * k));
          chk("stall_wr", o_mem_wr, !l);
        end
        i_start = 0;
        if (k == abort_beat) begin i_mem_abort = 1; i_mem_ack = 1'($urandom); end
        else i_mem_ack = 1;
        @(negedge clk);
        i_mem_ack = 0; i_mem_abort = 0;
        if (k == abort_beat) begin aborted = 1; break; end
      end
    end
    chk("end_req", o_mem_req, 0);
    done = o_done; abrt = o_abort; wbvld = o_wb_valid; wbv = o_wb_value;
    chk("end_done", o_done, !aborted);
    chk("end_abort", o_abort, aborted);
    chk("end_wbvld", o_wb_valid, aborted ? 1'b1 : (w && n > 0));
    if (aborted) chk("end_wbval_abort", o_wb_value, mis ? base : b);
    else if (w && n > 0) chk("end_wbval", o_wb_value, exp_wb);
    @(negedge clk);
    chk_quiet("after");
  endtask

  logic [31:0] fa, wv;
  logic        wvld, dn, ab;

  initial begin
    tbl[0] = '{32'h0000_1000, 16'h000A, 1'b0, 1'b1, 1'b0, 1'b1, -1, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 32'h0000_1008};
    tbl[1] = '{32'h0000_2000, 16'h8003, 1'b1, 1'b0, 1'b1, 1'b1, -1, 32'h0000_1FF4, 1'b1, 1'b0, 1'b1, 32'h0000_1FF4};
    tbl[2] = '{32'h0000_3000, 16'h0070, 1'b1, 1'b1, 1'b1, 1'b0,  1, 32'h0000_3004, 1'b0, 1'b1, 1'b1, 32'h0000_3000};
    tbl[3] = '{32'h0000_5000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, -1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'hFFFF_FFF0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, -1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1, 32'h0000_0030};
    tbl[5] = '{32'h0000_0100, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, -1, 32'h0000_00FC, 1'b1, 1'b0, 1'b1, 32'h0000_00F8};
`ifdef ZAP_BLOCK_XFER_ALIGN_CHK_EN
    tbl[6] = '{32'h0000_1002, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, -1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_1002};
`else
    tbl[6] = '{32'h0000_1002, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, -1, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 32'h0000_1004};
`endif
    tbl[7] = '{32'h0000_8000, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0,  0, 32'h0000_7FF8, 1'b0, 1'b1, 1'b1, 32'h0000_8000};

    i_reset_n = 0; i_clear = 0; i_start = 0; i_base = '0; i_reglist = '0;
    i_pre_index = 0; i_up = 0; i_load = 0; i_writeback = 0; i_mem_ack = 0; i_mem_abort = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {o_busy, o_mem_req, o_mem_wr, o_done, o_abort, o_wb_valid, o_mem_reg}, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wbval", o_wb_value, 0);
    i_reset_n = 1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      run_xfer(tbl[t].base, tbl[t].list, tbl[t].p, tbl[t].u, tbl[t].l, tbl[t].w,
               tbl[t].abort_beat, 0, 0, fa, wv, wvld, dn, ab);
      if (tbl[t].list != 0 && tbl[t].exp_done) chk($sformatf("tbl%0d_first", t), fa, tbl[t].exp_first);
      chk($sformatf("tbl%0d_done", t), dn, tbl[t].exp_done);
      chk($sformatf("tbl%0d_abort", t), ab, tbl[t].exp_abort);
      chk($sformatf("tbl%0d_wbvld", t), wvld, tbl[t].exp_wbvld);
      if (tbl[t].exp_wbvld) chk($sformatf("tbl%0d_wbval", t), wv, tbl[t].exp_wb);
    end

    // Flush after one of four acks: bus drops next cycle, no pulses, then a new transfer runs.
    i_base = 32'h4000; i_reglist = 16'h000F; i_pre_index = 0; i_up = 1; i_load = 1; i_writeback = 1;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    chk("clr_beat0", o_mem_addr, 32'h4000);
    i_mem_ack = 1;
    @(negedge clk);
    chk("clr_beat1", o_mem_addr, 32'h4004);
    i_clear = 1;
    @(negedge clk);
    i_clear = 0; i_mem_ack = 0;
    chk_quiet("clr_next");
    chk("clr_addr", o_mem_addr, 0);
    @(negedge clk);
    chk_quiet("clr_next2");
    run_xfer(32'h4100, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 0, fa, wv, wvld, dn, ab);
    chk("clr_restart_first", fa, 32'h4104);

    // Ack/abort with no request outstanding must do nothing.
    i_mem_ack = 1; i_mem_abort = 1;
    @(negedge clk);
    i_mem_ack = 0; i_mem_abort = 0;
    chk_quiet("idle_ack");
    @(negedge clk);
    chk_quiet("idle_ack2");

    // Asynchronous reset in the middle of a request.
    i_base = 32'h6000; i_reglist = 16'h0003; i_pre_index = 0; i_up = 1; i_load = 0; i_writeback = 1;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    chk("arst_pre_req", o_mem_req, 1);
    #2 i_reset_n = 0;
    #1;
    chk("arst_ctrl", {o_busy, o_mem_req, o_mem_wr, o_done, o_abort, o_wb_valid, o_mem_reg}, 0);
    chk("arst_addr", o_mem_addr, 0);
    chk("arst_wbval", o_wb_value, 0);
    @(negedge clk);
    i_reset_n = 1;
    @(negedge clk);
    chk_quiet("arst_after");

    for (int r = 0; r < 40; r++) begin
      logic [15:0] lst;
      int ab_beat;
      lst = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      ab_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      run_xfer($urandom, lst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ab_beat, 2, 1, fa, wv, wvld, dn, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
